sobel_window_feeder: RTL and testbench

- Producer side of the Sobel window stream: fetches pixels from the frame buffer and emits them in the order the Sobel window consumer expects.
- Image is walked in vertical strips 3 pixels wide; each strip opens with a full 3x3 window (9 pixels, row-major), then sends 3 pixels per new bottom row as the window slides down.
- Sits between the frame-buffer read port and the Sobel control/core pipeline.

---
 rtl/sobel_window_feeder.sv | 164 ++++++++++++++++
 tb/tb_sobel_window_feeder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/sobel_window_feeder.sv
// Sobel window stream producer: walks the frame in 3-pixel-wide vertical strips,
// fetching each strip's first 3x3 window and then 3 pixels per new bottom row.
module sobel_window_feeder #(
    parameter int PIXEL_W    = 8,
    parameter int IMG_W      = 16,
    parameter int IMG_H      = 16,
    parameter int ADDR_W     = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic               clk_i,
    input  logic               nreset_i,
    input  logic               start_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               mem_req_o,
    output logic [ADDR_W-1:0]  mem_addr_o,
    input  logic               mem_ack_i,
    input  logic [PIXEL_W-1:0] mem_data_i,
    output logic               start_sobel_o,
    output logic [PIXEL_W-1:0] px_o,
    output logic               px_rdy_o
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1) + 1;

    typedef enum logic [1:0] {IDLE, FETCH, GAP, DONE} state_t;

    state_t             state_q, state_d;
    logic [COL_W-1:0]   col_base_q, col_base_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [1:0]         k_q, k_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               mem_req_q, mem_req_d;
    logic               start_sobel_q, start_sobel_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [PIXEL_W-1:0] px_q, px_d;
    logic               px_rdy_q, px_rdy_d;
    logic               last_px, last_strip;

    function automatic logic [ADDR_W-1:0] pix_addr(input logic [ROW_W-1:0] r,
                                                   input logic [COL_W-1:0] cb,
                                                   input logic [1:0]       kk);
        return ADDR_W'(r) * ADDR_W'(IMG_W) + ADDR_W'(cb) + ADDR_W'(kk);
    endfunction

    // Every strip row is fetched left to right, so the opening 3x3 window is
    // just the first three rows of that walk.
    assign last_px    = (row_q == ROW_W'(IMG_H - 1)) && (k_q == 2'd2);
    assign last_strip = (col_base_q == COL_W'(IMG_W - 3));

    always_comb begin
        state_d       = state_q;
        col_base_d    = col_base_q;
        row_d         = row_q;
        k_d           = k_q;
        gap_cnt_d     = gap_cnt_q;
        addr_d        = addr_q;
        mem_req_d     = mem_req_q;
        start_sobel_d = start_sobel_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        px_d          = px_q;
        px_rdy_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d       = FETCH;
                    col_base_d    = '0;
                    row_d         = '0;
                    k_d           = '0;
                    addr_d        = '0;
                    mem_req_d     = 1'b1;
                    start_sobel_d = 1'b1;
                    busy_d        = 1'b1;
                end
            end
            FETCH: begin
                if (mem_req_q && mem_ack_i) begin
                    px_d     = mem_data_i;
                    px_rdy_d = 1'b1;
                    if (k_q == 2'd2) begin
                        k_d   = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        k_d = k_q + 2'd1;
                    end
                    if (last_px) begin
                        mem_req_d = 1'b0;
                        row_d     = '0;
                        k_d       = '0;
                        gap_cnt_d = '0;
                        state_d   = last_strip ? DONE : GAP;
                    end
                    addr_d = pix_addr(row_d, col_base_q, k_d);
                end
            end
            GAP: begin
                // First GAP cycle still carries the strip's final px_rdy_o.
                start_sobel_d = 1'b0;
                if (gap_cnt_q == GAP_W'(GAP_CYCLES)) begin
                    state_d       = FETCH;
                    col_base_d    = col_base_q + 1'b1;
                    row_d         = '0;
                    k_d           = '0;
                    addr_d        = pix_addr('0, col_base_q + 1'b1, 2'd0);
                    mem_req_d     = 1'b1;
                    start_sobel_d = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            DONE: begin
                start_sobel_d = 1'b0;
                busy_d        = 1'b0;
                done_d        = 1'b1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_q       <= IDLE;
            col_base_q    <= '0;
            row_q         <= '0;
            k_q           <= '0;
            gap_cnt_q     <= '0;
            addr_q        <= '0;
            mem_req_q     <= 1'b0;
            start_sobel_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            px_q          <= '0;
            px_rdy_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            col_base_q    <= col_base_d;
            row_q         <= row_d;
            k_q           <= k_d;
            gap_cnt_q     <= gap_cnt_d;
            addr_q        <= addr_d;
            mem_req_q     <= mem_req_d;
            start_sobel_q <= start_sobel_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            px_q          <= px_d;
            px_rdy_q      <= px_rdy_d;
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign mem_req_o     = mem_req_q;
    assign mem_addr_o    = addr_q;
    assign start_sobel_o = start_sobel_q;
    assign px_o          = px_q;
    assign px_rdy_o      = px_rdy_q;

endmodule

// File: tb/tb_sobel_window_feeder.sv
// Directed bench for sobel_window_feeder: 4x4 frame scenarios from a table,
// mid-frame reset, and a minimum 3x3 frame on a second instance.
module tb_sobel_window_feeder;

    logic clk = 1'b0;
    logic nreset = 1'b0;
    always #5 clk = ~clk;

    // 4x4 instance
    logic       start_i = 1'b0, mem_ack = 1'b0;
    logic [7:0] mem_data = 8'h00;
    logic       busy, done, mem_req, start_sobel, px_rdy;
    logic [7:0] mem_addr, px;

    sobel_window_feeder #(.PIXEL_W(8), .IMG_W(4), .IMG_H(4), .ADDR_W(8), .GAP_CYCLES(2)) u_dut (
        .clk_i(clk), .nreset_i(nreset), .start_i(start_i), .busy_o(busy), .done_o(done),
        .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_ack_i(mem_ack), .mem_data_i(mem_data),
        .start_sobel_o(start_sobel), .px_o(px), .px_rdy_o(px_rdy));

    // 3x3 instance
    logic       s3_start = 1'b0, s3_ack = 1'b0;
    logic [7:0] s3_data = 8'h00;
    logic       s3_busy, s3_done, s3_req, s3_ss, s3_rdy;
    logic [7:0] s3_addr, s3_px;

    sobel_window_feeder #(.PIXEL_W(8), .IMG_W(3), .IMG_H(3), .ADDR_W(8), .GAP_CYCLES(2)) u_dut3 (
        .clk_i(clk), .nreset_i(nreset), .start_i(s3_start), .busy_o(s3_busy), .done_o(s3_done),
        .mem_req_o(s3_req), .mem_addr_o(s3_addr), .mem_ack_i(s3_ack), .mem_data_i(s3_data),
        .start_sobel_o(s3_ss), .px_o(s3_px), .px_rdy_o(s3_rdy));

    int n_chk = 0, n_fail = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // monitor / memory model state for the 4x4 instance
    logic [7:0] cap[$];
    int  done_cnt, gap_runs, last_gap, cur_low, cur_run, max_run, rdy_low_viol, addr_viol;
    int  wait_n = 0, cnt = 0;
    bit  spur_start = 0, spur_ack = 0, spur_fired = 0, spur_active = 0;
    logic       prev_req = 0, prev_ack = 0;
    logic [7:0] prev_addr = 0;

    task automatic clear_mon();
        cap.delete();
        done_cnt = 0; gap_runs = 0; last_gap = 0; cur_low = 0; cur_run = 0;
        max_run = 0; rdy_low_viol = 0; addr_viol = 0; spur_fired = 0;
    endtask

    // Monitor first, then decide the memory response for the next posedge.
    initial begin
        forever begin
            @(negedge clk);
            if (px_rdy) begin
                cap.push_back(px);
                cur_run++;
                if (cur_run > max_run) max_run = cur_run;
                if (!start_sobel) rdy_low_viol++;
            end else cur_run = 0;
            if (done) done_cnt++;
            if (busy && !start_sobel) cur_low++;
            else begin
                if (cur_low > 0 && start_sobel) begin gap_runs++; last_gap = cur_low; end
                cur_low = 0;
            end
            if (prev_req && !prev_ack && mem_req && mem_addr != prev_addr) addr_viol++;
            prev_req = mem_req; prev_addr = mem_addr;

            if (mem_req) begin
                if (cnt >= wait_n) begin mem_ack = 1'b1; mem_data = mem_addr; cnt = 0; end
                else begin mem_ack = 1'b0; cnt++; end
            end else begin
                mem_ack  = spur_ack && busy && !start_sobel;
                mem_data = 8'hEE;
                cnt = 0;
            end
            prev_ack = mem_ack;

            if (spur_active) begin start_i = 1'b0; spur_active = 0; end
            else if (spur_start && busy && cap.size() == 5 && !spur_fired) begin
                start_i = 1'b1; spur_fired = 1; spur_active = 1;
            end
        end
    end

    // 3x3 instance: zero-wait memory returning data = addr
    logic [7:0] cap3[$];
    int cyc3 = 0, last_rdy3 = -1, done_cyc3 = -1, done3_cnt = 0, low3 = 0;
    initial begin
        forever begin
            @(negedge clk);
            cyc3++;
            if (s3_rdy) begin cap3.push_back(s3_px); last_rdy3 = cyc3; end
            if (s3_done) begin done3_cnt++; done_cyc3 = cyc3; end
            if (s3_busy && !s3_ss) low3++;
            s3_ack  = s3_req;
            s3_data = s3_addr;
        end
    end

    typedef struct {
        int wait_n;
        bit spur_start;
        bit spur_ack;
        int exp_run;
    } scen_t;

    scen_t      tbl[4];
    logic [7:0] exp_px[24];

    task automatic run_frame(input int s);
        wait_n = tbl[s].wait_n; spur_start = tbl[s].spur_start; spur_ack = tbl[s].spur_ack;
        @(negedge clk); #1;
        clear_mon();
        start_i = 1'b1;
        @(negedge clk); #1;
        start_i = 1'b0;
        check($sformatf("s%0d_first_req", s), mem_req, 1);
        check($sformatf("s%0d_first_addr", s), mem_addr, 0);
        check($sformatf("s%0d_first_busy", s), busy, 1);
        check($sformatf("s%0d_first_ss", s), start_sobel, 1);
        for (int i = 0; i < 2000 && done_cnt == 0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        #1;
        check($sformatf("s%0d_done_seen", s), int'(done_cnt > 0), 1);
        check($sformatf("s%0d_done_count", s), done_cnt, 1);
        check($sformatf("s%0d_px_count", s), cap.size(), 24);
        for (int i = 0; i < 24; i++)
            if (i < cap.size()) check($sformatf("s%0d_px[%0d]", s, i), cap[i], exp_px[i]);
        check($sformatf("s%0d_gap_runs", s), gap_runs, 1);
        check($sformatf("s%0d_gap_len", s), last_gap, 2);
        check($sformatf("s%0d_max_run", s), max_run, tbl[s].exp_run);
        check($sformatf("s%0d_rdy_wo_ss", s), rdy_low_viol, 0);
        check($sformatf("s%0d_addr_stable", s), addr_viol, 0);
        check($sformatf("s%0d_busy_end", s), busy, 0);
        spur_start = 0; spur_ack = 0;
    endtask

    initial begin
        tbl[0] = '{0, 1'b0, 1'b0, 12};
        tbl[1] = '{3, 1'b0, 1'b0, 1};
        tbl[2] = '{0, 1'b1, 1'b0, 12};
        tbl[3] = '{0, 1'b0, 1'b1, 12};
        exp_px = '{8'd0, 8'd1, 8'd2, 8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10, 8'd12, 8'd13, 8'd14,
                   8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11, 8'd13, 8'd14, 8'd15};
        clear_mon();

        repeat (3) @(negedge clk);
        nreset = 1'b1;
        @(negedge clk); #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_req", mem_req, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_ss", start_sobel, 0);
        check("rst_px", px, 0);
        check("rst_rdy", px_rdy, 0);
        check("rst3_req", s3_req, 0);

        for (int s = 0; s < 4; s++) run_frame(s);

        // mid-frame reset
        wait_n = 0;
        @(negedge clk); #1;
        clear_mon();
        start_i = 1'b1;
        @(negedge clk); #1;
        start_i = 1'b0;
        for (int i = 0; i < 200 && cap.size() < 5; i++) @(negedge clk);
        #1;
        check("mr_reached_5px", int'(cap.size() >= 5), 1);
        check("mr_rdy_before", px_rdy, 1);
        #2 nreset = 1'b0;
        #1;
        check("mr_req", mem_req, 0);
        check("mr_rdy", px_rdy, 0);
        check("mr_ss", start_sobel, 0);
        check("mr_busy", busy, 0);
        check("mr_done", done, 0);
        repeat (3) @(negedge clk);
        nreset = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        check("mr_no_done", done_cnt, 0);
        check("mr_idle_req", mem_req, 0);
        run_frame(0);

        // minimum 3x3 frame
        @(negedge clk); #1;
        s3_start = 1'b1;
        @(negedge clk); #1;
        s3_start = 1'b0;
        for (int i = 0; i < 200 && done3_cnt == 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        #1;
        check("m3_done_count", done3_cnt, 1);
        check("m3_px_count", cap3.size(), 9);
        for (int i = 0; i < 9; i++)
            if (i < cap3.size()) check($sformatf("m3_px[%0d]", i), cap3[i], i);
        check("m3_done_timing", done_cyc3, last_rdy3 + 1);
        check("m3_no_gap", low3, 0);
        check("m3_busy_end", s3_busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
